// File: rtl/bus_cycle_fsm.sv
// ---------------------------------------------------------------------------
// bus_cycle_fsm
//
// Main bus-cycle sequencer for the 68k-side interface. Accepts a start
// request from the host request logic, walks the bus drivers through the
// address/data strobe phases of each transfer, repeats for a burst of
// 1..2^BURST_W transfers and reports how the burst ended. The sequential
// bus drivers decode STATE directly, so the numeric state codes are fixed.
//
// Ports:
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   ACTIVATE       start request, only looked at while idle (WAIT)
//   BURST_LEN      number of extra transfers after the first, captured at start
//   LATCH          data-latch strobe
//   MC_CLK_RISING  one-cycle pulse on each 68k clock rising edge
//   AS_FEEDBACK    AS as seen on the bus
//   ENTER_S6       DSACK qualified, proceed to S6
//   BERR_IN        bus error from the bus
//   ABORT          host abort request, honoured between transfers only
//   STATE          current state code
//   BUSY           high whenever STATE is not WAIT
//   XFER_IDX       index of the current transfer within the burst
//   DONE           one-cycle pulse, burst completed (or aborted) normally
//   BUS_ERROR      one-cycle pulse, burst ended by BERR_IN or DSACK timeout
//   TIMED_OUT      sticky, set by a DSACK timeout, cleared by the next start
// ---------------------------------------------------------------------------
module bus_cycle_fsm #(
    parameter int BURST_W    = 2,
    parameter int TIMEOUT_W  = 8,
    parameter int TIMEOUT    = 200,
    parameter int TIMEOUT_EN = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ACTIVATE,
    input  logic [BURST_W-1:0] BURST_LEN,
    input  logic               LATCH,
    input  logic               MC_CLK_RISING,
    input  logic               AS_FEEDBACK,
    input  logic               ENTER_S6,
    input  logic               BERR_IN,
    input  logic               ABORT,
    output logic [3:0]         STATE,
    output logic               BUSY,
    output logic [BURST_W-1:0] XFER_IDX,
    output logic               DONE,
    output logic               BUS_ERROR,
    output logic               TIMED_OUT
);

    typedef enum logic [3:0] {
        ST_WAIT       = 4'd0,
        ST_ACTIVATE   = 4'd1,
        ST_SETUP_BUS  = 4'd2,
        ST_DRIVE_AS   = 4'd3,
        ST_DRIVE_DS   = 4'd4,
        ST_WAIT_DSACK = 4'd5,
        ST_WAIT_LATCH = 4'd6,
        ST_LATCH      = 4'd7,
        ST_CLEAR_AS   = 4'd8,
        ST_ON_DSACK   = 4'd9,
        ST_FINALIZE   = 4'd10,
        ST_ERROR      = 4'd11
    } state_t;

    // Last counter value before the timeout fires: the WAIT_DSACK entry
    // cycle counts as cycle 0, so the error edge lands exactly TIMEOUT
    // cycles after entering WAIT_DSACK.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX  = {TIMEOUT_W{1'b1}};

    state_t               state_q, state_d;
    logic [BURST_W-1:0]   remaining_q, remaining_d;
    logic [BURST_W-1:0]   xfer_idx_q, xfer_idx_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 done_q, done_d;
    logic                 bus_error_q, bus_error_d;
    logic                 timed_out_q, timed_out_d;
    logic                 as_released;
    logic                 tmo_hit;

    // AS must be seen released on a 68k clock rising edge before the bus
    // cycle is considered closed, both for normal and error termination.
    assign as_released = !AS_FEEDBACK && MC_CLK_RISING;
    assign tmo_hit     = (TIMEOUT_EN != 0) && (tmo_cnt_q == TMO_LAST);

    // State register and all sequencer bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_WAIT;
            remaining_q <= '0;
            xfer_idx_q  <= '0;
            tmo_cnt_q   <= '0;
            done_q      <= 1'b0;
            bus_error_q <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            xfer_idx_q  <= xfer_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            done_q      <= done_d;
            bus_error_q <= bus_error_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Next-state logic. DONE/BUS_ERROR default low so they only ever last
    // for the single cycle after the terminating edge; ABORT is sampled in
    // FINALIZE alone so a transfer already on the bus always completes.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        xfer_idx_d  = xfer_idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        done_d      = 1'b0;
        bus_error_d = 1'b0;
        timed_out_d = timed_out_q;

        case (state_q)
            ST_WAIT: begin
                if (ACTIVATE) begin
                    state_d     = ST_ACTIVATE;
                    remaining_d = BURST_LEN;
                    xfer_idx_d  = '0;
                    timed_out_d = 1'b0;
                end
            end
            ST_ACTIVATE:  state_d = ST_SETUP_BUS;
            ST_SETUP_BUS: state_d = ST_DRIVE_AS;
            ST_DRIVE_AS: begin
                if (AS_FEEDBACK) begin
                    state_d = ST_DRIVE_DS;
                end
            end
            ST_DRIVE_DS: begin
                state_d   = ST_WAIT_DSACK;
                tmo_cnt_d = '0;
            end
            ST_WAIT_DSACK: begin
                if (BERR_IN) begin
                    state_d = ST_ERROR;
                end else if (tmo_hit) begin
                    state_d     = ST_ERROR;
                    timed_out_d = 1'b1;
                end else if (ENTER_S6) begin
                    state_d = ST_WAIT_LATCH;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_WAIT_LATCH: begin
                if (LATCH) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH:    state_d = ST_CLEAR_AS;
            ST_CLEAR_AS: state_d = ST_ON_DSACK;
            ST_ON_DSACK: begin
                if (as_released) begin
                    state_d = ST_FINALIZE;
                end
            end
            ST_FINALIZE: begin
                if ((remaining_q != '0) && !ABORT) begin
                    state_d     = ST_SETUP_BUS;
                    remaining_d = remaining_q - BURST_W'(1);
                    xfer_idx_d  = xfer_idx_q + BURST_W'(1);
                end else begin
                    state_d = ST_WAIT;
                    done_d  = 1'b1;
                end
            end
            ST_ERROR: begin
                if (as_released) begin
                    state_d     = ST_WAIT;
                    bus_error_d = 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign STATE     = state_q;
    assign BUSY      = (state_q != ST_WAIT);
    assign XFER_IDX  = xfer_idx_q;
    assign DONE      = done_q;
    assign BUS_ERROR = bus_error_q;
    assign TIMED_OUT = timed_out_q;

endmodule

// File: doc/bus_cycle_fsm.md
Name: bus_cycle_fsm

Overview:
- Registered main bus-cycle FSM for the 68k-side interface: next-state logic and state register in one block.
- Adds parametrised burst count, DSACK timeout, external bus-error termination and abort.
- Sits between the host request logic (ACTIVATE, BURST_LEN) and the sequential bus drivers, which decode STATE.

Parameters:
- BURST_W, 2: width of BURST_LEN and XFER_IDX. A burst is 1..2^BURST_W transfers.
- TIMEOUT_W, 8: width of the DSACK timeout counter.
- TIMEOUT, 200: CLK cycles allowed in WAIT_DSACK before a forced bus error. Must be 1..2^TIMEOUT_W-1.
- TIMEOUT_EN, 1: 0 disables the timeout entirely.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ACTIVATE  in  1  start request, sampled in WAIT only
- BURST_LEN  in  BURST_W  additional transfers after the first; captured in ACTIVATE
- LATCH  in  1  data-latch strobe
- MC_CLK_RISING  in  1  one-cycle pulse on each 68k clock rising edge
- AS_FEEDBACK  in  1  AS as seen on the bus
- ENTER_S6  in  1  DSACK qualified, enter S6
- BERR_IN  in  1  bus error from the bus
- ABORT  in  1  host abort request
- STATE  out  4  current state
- BUSY  out  1  high whenever STATE != WAIT
- XFER_IDX  out  BURST_W  index of the current transfer within the burst
- DONE  out  1  one-cycle pulse: burst completed normally
- BUS_ERROR  out  1  one-cycle pulse: burst terminated by BERR_IN or timeout
- TIMED_OUT  out  1  sticky flag; cleared on next ACTIVATE acceptance or RESET

Behaviour:
- State encoding (4 bits):
  - WAIT=0, ACTIVATE=1, SETUP_BUS=2, DRIVE_AS=3, DRIVE_DS=4, WAIT_DSACK=5, WAIT_LATCH=6
  - LATCH=7, CLEAR_AS=8, ON_DSACK=9, FINALIZE=10, ERROR=11
  - Codes 12-15 go to WAIT on the next cycle.
- RESET: STATE=WAIT, XFER_IDX=0, remaining-count=0, timeout counter=0, DONE=0, BUS_ERROR=0, TIMED_OUT=0. RESET overrides every input.
- Transitions, evaluated on each CLK edge:
  - WAIT -> ACTIVATE if ACTIVATE. On the same edge: capture BURST_LEN into remaining-count, XFER_IDX<=0, TIMED_OUT<=0.
  - ACTIVATE -> SETUP_BUS unconditionally.
  - SETUP_BUS -> DRIVE_AS unconditionally.
  - DRIVE_AS -> DRIVE_DS when AS_FEEDBACK, else hold.
  - DRIVE_DS -> WAIT_DSACK; timeout counter <= 0.
  - WAIT_DSACK, priority order (BERR_IN, then timeout, then ENTER_S6):
    - BERR_IN -> ERROR.
    - else if TIMEOUT_EN and counter == TIMEOUT-1 -> ERROR, TIMED_OUT<=1.
    - else if ENTER_S6 -> WAIT_LATCH.
    - else hold, counter increments (saturating).
  - WAIT_LATCH -> LATCH when LATCH, else hold.
  - LATCH -> CLEAR_AS unconditionally.
  - CLEAR_AS -> ON_DSACK unconditionally.
  - ON_DSACK -> FINALIZE when !AS_FEEDBACK && MC_CLK_RISING, else hold.
  - FINALIZE:
    - if remaining-count != 0 and !ABORT: -> SETUP_BUS, remaining-count -1, XFER_IDX +1.
    - else: -> WAIT, DONE=1 for one cycle.
  - ERROR -> ON_DSACK-equivalent wait: holds until !AS_FEEDBACK && MC_CLK_RISING, then -> WAIT with BUS_ERROR=1 for one cycle. The burst is discarded and no further transfers occur.
- ABORT:
  - Honoured only at FINALIZE, so a bus cycle is never cut mid-transfer.
  - When honoured it ends the burst like a normal completion: DONE pulses.
  - ABORT in any other state is ignored and not latched.
- ACTIVATE outside WAIT is ignored.
- BURST_LEN changes after capture have no effect.
- XFER_IDX holds its last value after the burst until the next capture.
- DONE and BUS_ERROR are registered, asserted in the first cycle STATE==WAIT, and are mutually exclusive.
- Latency: ACTIVATE sampled -> STATE=DRIVE_AS after 3 edges, given AS_FEEDBACK already high.
- Reset mid-cycle: next edge STATE=WAIT with all outputs at reset values. No DONE or BUS_ERROR pulse.

Test Plan:
- Single transfer: BURST_LEN=0, ACTIVATE pulse, AS_FEEDBACK high after 2 cycles, ENTER_S6, LATCH, AS low with MC_CLK_RISING -> STATE sequence 0,1,2,3,...,9,10,0; DONE=1 exactly once; XFER_IDX=0.
- Burst: BURST_LEN=3 -> four SETUP_BUS entries, XFER_IDX 0,1,2,3; single DONE after the 4th FINALIZE.
- Timeout: TIMEOUT=200, ENTER_S6 never asserts -> ERROR entered exactly 200 cycles after entering WAIT_DSACK; TIMED_OUT=1; BUS_ERROR pulses once after AS release; no DONE.
- BERR_IN and ENTER_S6 high in the same WAIT_DSACK cycle -> ERROR taken. In a separate BERR-free run, ABORT pulsed in WAIT_LATCH is ignored.
- ABORT at FINALIZE of transfer 1 of BURST_LEN=3 -> WAIT next cycle, DONE=1, XFER_IDX=1.
- RESET asserted in ON_DSACK -> next edge STATE=0, BUSY=0, TIMED_OUT=0, no pulses; fresh ACTIVATE then runs a normal cycle.
